// File: rtl/balanca_pkg.sv
// Shared types and constants for the weighing-scale price controller.
package balanca_pkg;

  localparam int W_PESO = 14;
  localparam int W_CENT = 9;
  localparam int W_PROD = 23;
  localparam int W_TOTC = 14;

  // Divisors; named with a K_ prefix so they do not clash with the state names
  localparam int K_DIV_MIL = 1000;
  localparam int K_DIV_CEM = 100;

  localparam int CICLOS_MUL     = 14;
  localparam int CICLOS_DIV_MIL = 23;
  localparam int CICLOS_DIV_CEM = 14;

  // Width of the step counter inside the divider (must hold CICLOS_DIV_MIL)
  localparam int W_PASSOS = 5;

  typedef enum logic [2:0] {
    IDLE,
    ESPERA,
    MUL,
    DIV_MIL,
    DIV_CEM,
    DONE
  } estado_t;

endpackage

// File: rtl/balanca_controlador_divisor_restauracao.sv
// One-bit-per-cycle restoring divider. The start cycle already performs the
// first iteration from the input operands, so an N-step division finishes on
// the N-th edge counted from the start edge. done_o flags the cycle whose
// edge performs the last iteration; the results are then held until the
// next start. Dividends narrower than W must be left-aligned by the caller.
module divisor_restauracao
  import balanca_pkg::*;
#(
  parameter int W  = W_PROD,
  parameter int WC = W_PASSOS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [W-1:0]  dividendo_i,
  input  logic [W-1:0]  divisor_i,
  input  logic [WC-1:0] n_passos_i,
  output logic [W-1:0]  quociente_o,
  output logic [W-1:0]  resto_o,
  output logic          ocupado_o,
  output logic          done_o
);

  logic [W-1:0]  resto_q, resto_d;
  logic [W-1:0]  quoc_q, quoc_d;
  logic [WC-1:0] cnt_q;
  logic          ocupado_q;

  // One restoring iteration, taken from the inputs on start, else from state
  always_comb begin
    logic [W-1:0] resto_base;
    logic [W-1:0] quoc_base;
    logic [W-1:0] resto_sh;
    logic         bit_q;
    resto_base = start_i ? '0 : resto_q;
    quoc_base  = start_i ? dividendo_i : quoc_q;
    resto_sh   = {resto_base[W-2:0], quoc_base[W-1]};
    bit_q      = (resto_sh >= divisor_i);
    resto_d    = bit_q ? (resto_sh - divisor_i) : resto_sh;
    quoc_d     = {quoc_base[W-2:0], bit_q};
  end

  // Iteration registers and step down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resto_q   <= '0;
      quoc_q    <= '0;
      cnt_q     <= '0;
      ocupado_q <= 1'b0;
    end else if (start_i) begin
      resto_q   <= resto_d;
      quoc_q    <= quoc_d;
      cnt_q     <= n_passos_i - WC'(1);
      ocupado_q <= 1'b1;
    end else if (ocupado_q) begin
      resto_q <= resto_d;
      quoc_q  <= quoc_d;
      cnt_q   <= cnt_q - WC'(1);
      if (cnt_q == WC'(1)) ocupado_q <= 1'b0;
    end
  end

  assign quociente_o = quoc_q;
  assign resto_o     = resto_q;
  assign ocupado_o   = ocupado_q;
  assign done_o      = ocupado_q && (cnt_q == WC'(1));

endmodule

// File: rtl/balanca_controlador.sv
// Price controller for the weighing scale: stability detection, tare
// register and price = centimos * (weight - tare) via shift-add multiply and
// two passes of a shared restoring divider. Result reaches DONE 51 edges
// after the operand-latching edge.
// Optional: define BALANCA_ARREDONDA_EN to round the total cents to nearest
// (remainder >= 500) instead of truncating.
//
// state   | meaning
// IDLE    | waiting for tare / weigh pulses
// ESPERA  | weigh requested, waiting for a stable sample
// MUL     | 14-cycle shift-add product
// DIV_MIL | 23-cycle divide of product by 1000 (total cents)
// DIV_CEM | 14-cycle divide of total cents by 100 (euros / cents)
// DONE    | result valid, waiting for out_ready
module balanca_controlador
  import balanca_pkg::*;
#(
  parameter int STABLE_CNT = 8,
  parameter int TARA_RESET = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_PESO-1:0] peso_gramas_i,
  input  logic              peso_valido_i,
  input  logic [W_CENT-1:0] centimos_i,
  input  logic              botao_tara_i,
  input  logic              botao_pesar_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [W_TOTC-1:0] preco_inteiro_o,
  output logic [6:0]        preco_fracao_o,
  output logic [W_PESO-1:0] tara_atual_o,
  output logic              estavel_o,
  output logic              erro_tara_o,
  output logic              ocupado_o
);

  localparam logic [7:0]        EST_MAX  = 8'(STABLE_CNT);
  localparam logic [W_PESO-1:0] TARA_INI = W_PESO'(TARA_RESET);

  estado_t estado_q, estado_d;

  logic [W_PESO-1:0] amostra_q;
  logic [7:0]        cnt_est_q;
  logic [W_PESO-1:0] tara_q;
  logic              estavel;

  logic [W_PROD-1:0] mcand_q;
  logic [W_PESO-1:0] mplier_q;
  logic [W_PROD-1:0] prod_q;
  logic [3:0]        cnt_mul_q;
  logic              erro_r_q;
  logic              erro_tara_q;

  logic [W_PESO-1:0] net;
  logic [W_TOTC-1:0] totc;

  logic                div_start;
  logic [W_PROD-1:0]   div_dividendo;
  logic [W_PROD-1:0]   div_divisor;
  logic [W_PASSOS-1:0] div_passos;
  logic [W_PROD-1:0]   div_quoc;
  logic [W_PROD-1:0]   div_resto;
  logic                div_ocupado;
  logic                div_done;
  logic                unused_bits;

  assign estavel = (cnt_est_q == EST_MAX);
  assign net     = (amostra_q >= tara_q) ? (amostra_q - tara_q) : '0;

  // Total cents handed to the second division, optionally rounded
`ifdef BALANCA_ARREDONDA_EN
  assign totc = div_quoc[W_TOTC-1:0] + W_TOTC'(div_resto >= W_PROD'(500));
`else
  assign totc = div_quoc[W_TOTC-1:0];
`endif

  // Quotient/remainder upper bits are always zero for these operand ranges
  assign unused_bits = ^{div_quoc[W_PROD-1:W_TOTC], div_resto[W_PROD-1:7]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= IDLE;
    else        estado_q <= estado_d;
  end

  // Next-state logic; tare pulse takes priority over a simultaneous weigh pulse
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      IDLE:    if (botao_pesar_i && !botao_tara_i) estado_d = ESPERA;
      ESPERA:  if (estavel) estado_d = MUL;
      MUL:     if (cnt_mul_q == 4'd0) estado_d = DIV_MIL;
      DIV_MIL: if (div_done) estado_d = DIV_CEM;
      DIV_CEM: if (div_done) estado_d = DONE;
      DONE:    if (out_ready_i) estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  // Outputs and divider control; the divider is idle and holds its result in DONE
  always_comb begin
    out_valid_o     = (estado_q == DONE);
    ocupado_o       = (estado_q != IDLE);
    preco_inteiro_o = '0;
    preco_fracao_o  = '0;
    if (estado_q == DONE) begin
      preco_inteiro_o = div_quoc[W_TOTC-1:0];
      preco_fracao_o  = div_resto[6:0];
    end
    div_start     = ((estado_q == DIV_MIL) || (estado_q == DIV_CEM)) && !div_ocupado;
    div_dividendo = prod_q;
    div_divisor   = W_PROD'(K_DIV_MIL);
    div_passos    = W_PASSOS'(CICLOS_DIV_MIL);
    if (estado_q == DIV_CEM) begin
      div_dividendo = {totc, {(W_PROD-W_TOTC){1'b0}}};
      div_divisor   = W_PROD'(K_DIV_CEM);
      div_passos    = W_PASSOS'(CICLOS_DIV_CEM);
    end
  end

  // Stability counter, independent of the FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amostra_q <= '0;
      cnt_est_q <= '0;
    end else if (peso_valido_i) begin
      if (peso_gramas_i == amostra_q) begin
        if (cnt_est_q != EST_MAX) cnt_est_q <= cnt_est_q + 8'd1;
      end else begin
        amostra_q <= peso_gramas_i;
        cnt_est_q <= 8'd1;
      end
    end
  end

  // Tare capture, only from IDLE with a stable reading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          tara_q <= TARA_INI;
    else if ((estado_q == IDLE) && botao_tara_i && estavel) tara_q <= amostra_q;
  end

  // Operand latch and shift-add multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_mul_q <= '0;
      erro_r_q  <= 1'b0;
    end else if ((estado_q == ESPERA) && estavel) begin
      mcand_q   <= W_PROD'(centimos_i);
      mplier_q  <= net;
      prod_q    <= '0;
      cnt_mul_q <= 4'(CICLOS_MUL - 1);
      erro_r_q  <= (amostra_q < tara_q);
    end else if (estado_q == MUL) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q   <= {mcand_q[W_PROD-2:0], 1'b0};
      mplier_q  <= {1'b0, mplier_q[W_PESO-1:1]};
      cnt_mul_q <= cnt_mul_q - 4'd1;
    end
  end

  // Error flag published together with the result on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   erro_tara_q <= 1'b0;
    else if ((estado_q == DIV_CEM) && div_done)  erro_tara_q <= erro_r_q;
  end

  divisor_restauracao #(
    .W  (W_PROD),
    .WC (W_PASSOS)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividendo_i (div_dividendo),
    .divisor_i   (div_divisor),
    .n_passos_i  (div_passos),
    .quociente_o (div_quoc),
    .resto_o     (div_resto),
    .ocupado_o   (div_ocupado),
    .done_o      (div_done)
  );

  assign tara_atual_o = tara_q;
  assign estavel_o    = estavel;
  assign erro_tara_o  = erro_tara_q;

endmodule

// File: tb/tb_balanca_controlador.sv
// Testbench for balanca_controlador: expected prices are computed from the
// arithmetic definition and queued when a weigh is requested, then popped
// and compared when out_valid appears.
module tb_balanca_controlador;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] peso_gramas;
  logic        peso_valido;
  logic [8:0]  centimos;
  logic        botao_tara;
  logic        botao_pesar;
  logic        out_ready;
  logic        out_valid;
  logic [13:0] preco_inteiro;
  logic [6:0]  preco_fracao;
  logic [13:0] tara_atual;
  logic        estavel;
  logic        erro_tara;
  logic        ocupado;

  typedef struct {
    int eur;
    int cent;
    int erro;
  } esperado_t;

  esperado_t sb[$];
  int n_checks = 0;
  int n_erros  = 0;

  balanca_controlador #(.STABLE_CNT(8), .TARA_RESET(40)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .peso_gramas_i   (peso_gramas),
    .peso_valido_i   (peso_valido),
    .centimos_i      (centimos),
    .botao_tara_i    (botao_tara),
    .botao_pesar_i   (botao_pesar),
    .out_ready_i     (out_ready),
    .out_valid_o     (out_valid),
    .preco_inteiro_o (preco_inteiro),
    .preco_fracao_o  (preco_fracao),
    .tara_atual_o    (tara_atual),
    .estavel_o       (estavel),
    .erro_tara_o     (erro_tara),
    .ocupado_o       (ocupado)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input int obs, input int esp);
    n_checks++;
    if (obs != esp) begin
      n_erros++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alimenta(input int valor, input int n);
    for (int i = 0; i < n; i++) begin
      peso_gramas = 14'(valor);
      peso_valido = 1'b1;
      tick();
    end
    peso_valido = 1'b0;
  endtask

  task automatic pulso_pesar();
    botao_pesar = 1'b1;
    tick();
    botao_pesar = 1'b0;
  endtask

  task automatic pulso_tara();
    botao_tara = 1'b1;
    tick();
    botao_tara = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    tick();
  endtask

  // Arithmetic reference for one weigh request
  task automatic empurra(input int amostra, input int tara, input int cent);
    esperado_t e;
    int net, p, totc;
    e.erro = (amostra < tara) ? 1 : 0;
    net    = (amostra < tara) ? 0 : amostra - tara;
    p      = cent * net;
`ifdef BALANCA_ARREDONDA_EN
    totc   = p / 1000 + (((p % 1000) >= 500) ? 1 : 0);
    e.eur  = totc / 100;
    e.cent = totc % 100;
`else
    totc   = 0;
    e.eur  = p / 100000;
    e.cent = (p % 100000) / 1000;
`endif
    sb.push_back(e);
  endtask

  // Waits for out_valid, checks against the scoreboard, holds ready low, then accepts
  task automatic recebe(input int espera_ready, output int latencia);
    esperado_t e;
    latencia = 0;
    while (!out_valid && latencia < 3000) begin
      tick();
      latencia++;
    end
    if (!out_valid) begin
      verifica("timeout_out_valid", int'(out_valid), 1);
      return;
    end
    if (sb.size() == 0) begin
      verifica("sb_inesperado", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    verifica("preco_inteiro", int'(preco_inteiro), e.eur);
    verifica("preco_fracao", int'(preco_fracao), e.cent);
    verifica("erro_tara", int'(erro_tara), e.erro);
    for (int i = 0; i < espera_ready; i++) begin
      tick();
      verifica("hold_valid", int'(out_valid), 1);
      verifica("hold_inteiro", int'(preco_inteiro), e.eur);
      verifica("hold_fracao", int'(preco_fracao), e.cent);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    verifica("valid_apos_ready", int'(out_valid), 0);
    verifica("ocupado_apos_ready", int'(ocupado), 0);
  endtask

  initial begin
    int lat;
    rst_n       = 1'b0;
    peso_gramas = '0;
    peso_valido = 1'b0;
    centimos    = '0;
    botao_tara  = 1'b0;
    botao_pesar = 1'b0;
    out_ready   = 1'b0;

    // Reset values
    #12;
    verifica("rst_out_valid", int'(out_valid), 0);
    verifica("rst_tara", int'(tara_atual), 40);
    verifica("rst_inteiro", int'(preco_inteiro), 0);
    verifica("rst_estavel", int'(estavel), 0);
    verifica("rst_ocupado", int'(ocupado), 0);
    rst_n = 1'b1;
    tick();

    // 1040 g at 2.50 EUR/kg with default tare 40 -> 2.50 EUR
    alimenta(1040, 7);
    verifica("estavel_7", int'(estavel), 0);
    alimenta(1040, 1);
    verifica("estavel_8", int'(estavel), 1);
    centimos = 9'd250;
    empurra(1040, 40, 250);
    pulso_pesar();
    recebe(0, lat);
    // pesar edge, latch one edge later, DONE 51 edges after the latch
    verifica("latencia", lat, 52);
    verifica("tara_inalterada", int'(tara_atual), 40);

    // Tare 500, then 3000 g at 1.99 -> 4.97 (4.98 rounded); inputs change after latch
    alimenta(500, 8);
    pulso_tara();
    verifica("tara_500", int'(tara_atual), 500);
    alimenta(3000, 8);
    centimos = 9'd199;
    empurra(3000, 500, 199);
    pulso_pesar();
    tick();
    tick();
    centimos = 9'd1;
    alimenta(100, 4);
    recebe(0, lat);

    // Unstable samples keep the FSM in ESPERA
    centimos = 9'd123;
    for (int i = 0; i < 5; i++) begin
      alimenta(1000, 1);
      alimenta(1001, 1);
    end
    empurra(1001, 500, 123);
    pulso_pesar();
    for (int i = 0; i < 10; i++) begin
      alimenta(1000, 1);
      alimenta(1001, 1);
    end
    verifica("espera_ocupado", int'(ocupado), 1);
    verifica("espera_valid", int'(out_valid), 0);
    verifica("espera_estavel", int'(estavel), 0);
    alimenta(1001, 8);
    recebe(0, lat);

    // Negative net weight with tare 40 -> error flag, zero price, ready held low
    reset_dut();
    verifica("rst2_tara", int'(tara_atual), 40);
    alimenta(20, 8);
    centimos = 9'd300;
    empurra(20, 40, 300);
    pulso_pesar();
    recebe(10, lat);

    // Reset during MUL aborts the computation
    alimenta(1040, 8);
    pulso_tara();
    verifica("tara_1040", int'(tara_atual), 1040);
    centimos = 9'd250;
    pulso_pesar();
    for (int i = 0; i < 5; i++) tick();
    verifica("mul_ocupado", int'(ocupado), 1);
    rst_n = 1'b0;
    #1;
    verifica("abort_valid", int'(out_valid), 0);
    verifica("abort_ocupado", int'(ocupado), 0);
    verifica("abort_tara", int'(tara_atual), 40);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    verifica("abort_sem_resultado", int'(out_valid), 0);

    // Simultaneous tare and weigh in IDLE: tare wins, weigh dropped
    alimenta(700, 8);
    botao_tara  = 1'b1;
    botao_pesar = 1'b1;
    tick();
    botao_tara  = 1'b0;
    botao_pesar = 1'b0;
    verifica("ambos_tara", int'(tara_atual), 700);
    verifica("ambos_ocupado", int'(ocupado), 0);
    tick();
    tick();
    verifica("ambos_idle", int'(ocupado), 0);

    verifica("sb_final", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule
